// File: rtl/sha256_pkg.sv
// Shared SHA-256 front-end definitions: widths, padding constants, FSM encodings
// and the initial hash value used by both the padder and the compression core.
package sha256_pkg;

    localparam int BLK_W     = 512;
    localparam int WORD_W    = 32;
    localparam int BLK_WORDS = BLK_W / WORD_W;

    localparam logic [WORD_W-1:0] PAD_MARKER = 32'h80000000;

    // H0..H7, H0 in the most significant word.
    localparam logic [255:0] H_INIT = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FILL,
        MARK,
        LEN,
        EMIT
    } state_t;

    // Padding step deferred to the next block when the current one overflows.
    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_MARK,
        PEND_LEN
    } pend_t;

    function automatic word_t h_init_word(input int unsigned i);
        return H_INIT[255-32*i -: 32];
    endfunction

endpackage

// File: rtl/sha256_last_word_pad.sv
// Masks the final message word to its valid bytes and inserts the 0x80 marker
// right after them; a full final word passes through unchanged.
module sha256_last_word_pad
    import sha256_pkg::*;
(
    input  logic  [31:0] data,
    input  logic  [2:0]  n_bytes,
    output word_t        padded
);

    always_comb begin
        unique case (n_bytes)
            3'd0:    padded = PAD_MARKER;
            3'd1:    padded = {data[31:24], 24'h800000};
            3'd2:    padded = {data[31:16], 16'h8000};
            3'd3:    padded = {data[31:8],  8'h80};
            default: padded = data;
        endcase
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appends the 1-bit marker, zero fill and the 64-bit message bit length.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic [2:0]       in_bytes,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [BLK_W-1:0] blk_data,
    output logic             blk_first,
    output logic             blk_last
);

    state_t     state_q, state_d;
    pend_t      pend_q, pend_d;
    logic [4:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic       first_q, first_d;
    logic       last_q, last_d;
    logic [0:BLK_WORDS-1][WORD_W-1:0] blk_buf_q, blk_buf_d;

    word_t            pad_word;
    logic             full_last;
    logic [LEN_W-1:0] len_inc;
    logic [63:0]      len_field;

    sha256_last_word_pad u_last_word_pad (
        .data    (in_data),
        .n_bytes (in_bytes),
        .padded  (pad_word)
    );

    // Byte counts above 4 are treated as a full word.
    assign full_last = (in_bytes >= 3'd4);
    assign len_inc   = (in_last && !full_last) ? LEN_W'({in_bytes[1:0], 3'b000})
                                               : LEN_W'(32);
    assign len_field = 64'(len_q);

    assign blk_data  = blk_buf_q;
    assign blk_first = blk_valid & first_q;
    assign blk_last  = blk_valid & last_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        pend_d    = pend_q;
        idx_d     = idx_q;
        len_d     = len_q;
        first_d   = first_q;
        last_d    = last_q;
        blk_buf_d = blk_buf_q;
        in_ready  = 1'b0;
        blk_valid = 1'b0;

        unique case (state_q)
            FILL: begin
                in_ready = (idx_q < 5'd16);
                if (in_valid && in_ready) begin
                    blk_buf_d[idx_q[3:0]] = in_last ? pad_word : in_data;
                    idx_d = idx_q + 5'd1;
                    len_d = len_q + len_inc;
                    if (in_last) begin
                        state_d = full_last ? MARK : LEN;
                    end else if (idx_q == 5'd15) begin
                        state_d = EMIT;
                        last_d  = 1'b0;
                        pend_d  = PEND_NONE;
                    end
                end
            end

            MARK: begin
                if (idx_q == 5'd16) begin
                    state_d = EMIT;
                    last_d  = 1'b0;
                    pend_d  = PEND_MARK;
                end else begin
                    blk_buf_d[idx_q[3:0]] = PAD_MARKER;
                    idx_d   = idx_q + 5'd1;
                    state_d = LEN;
                end
            end

            LEN: begin
                state_d = EMIT;
                if (idx_q <= 5'd14) begin
                    blk_buf_d[14] = len_field[63:32];
                    blk_buf_d[15] = len_field[31:0];
                    last_d = 1'b1;
                    pend_d = PEND_NONE;
                end else begin
                    // Words 14/15 are taken; the length goes into a fresh block.
                    last_d = 1'b0;
                    pend_d = PEND_LEN;
                end
            end

            EMIT: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    blk_buf_d = '0;
                    idx_d     = '0;
                    first_d   = last_q;
                    pend_d    = PEND_NONE;
                    if (last_q) len_d = '0;
                    unique case (pend_q)
                        PEND_MARK: state_d = MARK;
                        PEND_LEN:  state_d = LEN;
                        default:   state_d = FILL;
                    endcase
                end
            end

            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            pend_q    <= PEND_NONE;
            idx_q     <= '0;
            len_q     <= '0;
            first_q   <= 1'b1;
            last_q    <= 1'b0;
            // NOTE: the buffer is reset on purpose: zero fill relies on it starting clear.
            blk_buf_q <= '0;
        end else begin
            // NOTE: non-blocking updates so all state advances together on the edge.
            state_q   <= state_d;
            pend_q    <= pend_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            first_q   <= first_d;
            last_q    <= last_d;
            blk_buf_q <= blk_buf_d;
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: table-driven lengths, hand-written corner
// sequences and randomized messages compared against a byte-level padding model.
module tb_sha256_padder;
    import sha256_pkg::*;

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    typedef struct {
        int          nbytes;
        int          exp_blocks;
        logic [31:0] exp_tail;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;

    int   checks = 0;
    int   errors = 0;
    bit   ready_auto = 1'b1;
    bit   ready_rand = 1'b0;
    blk_t got[$];
    blk_t exp_q[$];
    blk_t mon_b;

    localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h00000000}}, 32'h00000018};

    always #5 clk = ~clk;

    sha256_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    always @(posedge clk) begin
        #1;
        if (ready_auto) blk_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Inputs settle 1 unit after each rising edge, so the falling edge sees the handshake.
    always @(negedge clk) begin
        if (!rst && blk_valid && blk_ready) begin
            mon_b.data  = blk_data;
            mon_b.first = blk_first;
            mon_b.last  = blk_last;
            got.push_back(mon_b);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Standard SHA-256 padding at byte level: 0x80, zeros to 56 mod 64, 64-bit length.
    function automatic void build_ref(input byte unsigned msg[$]);
        byte unsigned p[$];
        longint unsigned bits;
        int nblk;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = longint'(msg.size()) * 8;
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        nblk = p.size() / 64;
        exp_q.delete();
        for (int b = 0; b < nblk; b++) begin
            blk_t x;
            x.data = '0;
            for (int i = 0; i < 64; i++) x.data[511-8*i -: 8] = p[64*b+i];
            x.first = (b == 0);
            x.last  = (b == nblk - 1);
            exp_q.push_back(x);
        end
    endfunction

    task automatic send_word(input logic [31:0] d, input logic last, input int nb, input bit gaps);
        bit acc = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = 3'(nb);
        for (int c = 0; c < 2000 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
        check("word_accept", 512'(acc), 512'(1));
    endtask

    task automatic send_msg(input byte unsigned msg[$], input bit gaps);
        int nw;
        int nb;
        logic [31:0] d;
        nw = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            d  = $urandom;
            nb = (w == nw - 1) ? msg.size() - 4 * w : 4;
            for (int i = 0; i < nb; i++) d[31-8*i -: 8] = msg[4*w+i];
            send_word(d, w == nw - 1, nb, gaps);
        end
    endtask

    // exp_blocks < 0 means take the block count from the model.
    task automatic run_msg(input string name, input byte unsigned msg[$], input bit gaps,
                           input int exp_blocks);
        bit done = 1'b0;
        got.delete();
        build_ref(msg);
        send_msg(msg, gaps);
        for (int c = 0; c < 4000 && !done; c++) begin
            done = (got.size() != 0) && got[got.size()-1].last;
            if (!done) begin
                @(posedge clk);
                #1;
            end
        end
        check({name, " done"}, 512'(done), 512'(1));
        check({name, " nblocks"}, 512'(got.size()),
              512'((exp_blocks >= 0) ? exp_blocks : exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check($sformatf("%s blk%0d data", name, i), got[i].data, exp_q[i].data);
            check($sformatf("%s blk%0d first", name, i), 512'(got[i].first), 512'(exp_q[i].first));
            check($sformatf("%s blk%0d last", name, i), 512'(got[i].last), 512'(exp_q[i].last));
        end
    endtask

    initial begin
        vec_t vecs[14];
        byte unsigned m[$];
        logic [511:0] snap;
        bit acc;
        bit stable;
        int n0;

        vecs = '{
            '{0,   1, 32'h00000000}, '{1,   1, 32'h00000008}, '{3,   1, 32'h00000018},
            '{4,   1, 32'h00000020}, '{52,  1, 32'h000001A0}, '{55,  1, 32'h000001B8},
            '{56,  2, 32'h000001C0}, '{60,  2, 32'h000001E0}, '{63,  2, 32'h000001F8},
            '{64,  2, 32'h00000200}, '{65,  2, 32'h00000208}, '{119, 2, 32'h000003B8},
            '{120, 3, 32'h000003C0}, '{128, 3, 32'h00000400}
        };

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_bytes  = '0;
        blk_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 512'(in_ready), 512'(1));
        check("reset blk_valid", 512'(blk_valid), 512'(0));
        check("reset blk_data", blk_data, 512'(0));
        check("reset blk_first", 512'(blk_first), 512'(0));
        check("reset blk_last", 512'(blk_last), 512'(0));
        rst = 1'b0;

        // "abc" with consumer stalled: latency, contents, then backpressure hold.
        ready_auto = 1'b0;
        blk_ready  = 1'b0;
        got.delete();
        in_valid = 1'b1;
        in_data  = 32'h61626300;
        in_last  = 1'b1;
        in_bytes = 3'd3;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("abc accepted", 512'(acc), 512'(1));
        check("abc valid at T+1", 512'(blk_valid), 512'(0));
        @(posedge clk);
        #1;
        check("abc valid at T+2", 512'(blk_valid), 512'(1));
        check("abc data", blk_data, ABC_BLK);
        check("abc first", 512'(blk_first), 512'(1));
        check("abc last", 512'(blk_last), 512'(1));
        snap   = blk_data;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            stable &= blk_valid && (blk_data === snap) && !in_ready && blk_first && blk_last;
        end
        check("backpressure hold", 512'(stable), 512'(1));
        n0 = got.size();
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        check("release valid drops", 512'(blk_valid), 512'(0));
        check("release in_ready", 512'(in_ready), 512'(1));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("release one transfer", 512'(got.size()), 512'(n0 + 1));
        ready_auto = 1'b1;

        // Abort a partial message with reset, then "abc" must come out clean.
        @(posedge clk);
        #1;
        got.delete();
        for (int w = 0; w < 5; w++) send_word($urandom, 1'b0, 4, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort no block", 512'(got.size()), 512'(0));
        check("abort in_ready", 512'(in_ready), 512'(1));
        m = '{8'h61, 8'h62, 8'h63};
        run_msg("abc after reset", m, 1'b0, 1);
        if (got.size() != 0) begin
            check("abc after reset data", got[0].data, ABC_BLK);
            check("abc after reset first", 512'(got[0].first), 512'(1));
        end

        // Length table across the one/two/three block boundaries.
        for (int v = 0; v < 14; v++) begin
            m.delete();
            for (int i = 0; i < vecs[v].nbytes; i++) m.push_back(8'($urandom));
            run_msg($sformatf("len%0d", vecs[v].nbytes), m, 1'b0, vecs[v].exp_blocks);
            if (got.size() != 0)
                check($sformatf("len%0d tail", vecs[v].nbytes),
                      512'(got[got.size()-1].data[31:0]), 512'(vecs[v].exp_tail));
        end

        // Random lengths, input gaps and consumer stalls.
        ready_rand = 1'b1;
        for (int r = 0; r < 40; r++) begin
            m.delete();
            n0 = $urandom_range(0, 200);
            for (int i = 0; i < n0; i++) m.push_back(8'($urandom));
            run_msg($sformatf("rand%0d len%0d", r, n0), m, 1'b1, -1);
        end
        ready_rand = 1'b0;

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
